pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 24 ++
 rtl/id_ex_ctrl_pipe_reg.sv | 40 ++++
 rtl/pipeline_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants for the ID/EX hazard controller: control-bundle bit
// positions, the default bundle width and the multiply/divide FSM encodings.
package pipeline_ctrl_pkg;

    // Default width of the decoded control bundle carried from ID to EX
    localparam int CTRL_W = 8;

    // Bit positions inside the control bundle
    localparam int REGWRITE = 0;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 2;
    localparam int MEMTOREG = 3;
    localparam int ALUSRC   = 4;
    localparam int ADDI     = 5;
    localparam int BRANCH   = 6;
    localparam int MULDIV   = 7;

    // Multiply/divide tracking FSM
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01
    } md_state_t;

endpackage

// File: rtl/id_ex_ctrl_pipe_reg.sv
// ID/EX pipeline register for the control bundle and destination fields.
// A bubble request loads an empty slot; otherwise the ID contents move in
// with the control bundle zeroed for non-valid slots.
module id_ex_ctrl_pipe_reg #(
    parameter int CTRL_W = 8
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              bubble,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd
);

    // Register stage: reset or bubble empties the slot, else ID advances
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rt    <= 5'd0;
            ex_rd    <= 5'd0;
        end else if (bubble) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_rt    <= 5'd0;
            ex_rd    <= 5'd0;
        end else begin
            ex_valid <= id_valid;
            ex_ctrl  <= id_valid ? id_ctrl : '0;
            ex_rt    <= id_rt;
            ex_rd    <= id_rd;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the ID/EX boundary of a 5-stage pipeline.
// Detects load-use and multiply/divide result hazards, applies branch
// flushes, tracks an outstanding muldiv and counts stall cycles.
//
// Flow control: the ID instruction is accepted into ID/EX on a clock edge
// exactly when stall_if_id=0 and flush_if_id=0. When stall_if_id=1 the
// front end must hold PC and IF/ID unchanged; when flush_if_id=1 IF/ID is
// squashed. In both cases ID/EX receives a bubble on that edge.
module pipeline_hazard_ctrl #(
    parameter int CTRL_W = pipeline_ctrl_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              id_valid,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_uses_hilo,
    input  logic              ex_branch_taken,
    input  logic              md_done,
    output logic              ex_valid,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic              stall_if_id,
    output logic              flush_if_id,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_count,
    output logic [1:0]        fsm_state
);

    import pipeline_ctrl_pkg::*;

    md_state_t state_q;
    md_state_t state_d;

    logic lu_hazard;
    logic md_hazard;
    logic bubble;
    logic accept_muldiv;

    // Load in EX whose destination is read by the ID instruction
    assign lu_hazard = reset_n & ex_valid & ex_ctrl[MEMREAD] & (ex_rt != 5'd0) & id_valid &
                       ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

    // HI/LO reader or new muldiv while a muldiv is still in flight
    assign md_hazard = reset_n & md_busy & id_valid & (id_uses_hilo | id_ctrl[MULDIV]) & ~md_done;

    // A taken branch squashes the ID instruction, so it overrides any stall
    assign flush_if_id = reset_n & ex_branch_taken;
    assign stall_if_id = reset_n & ~ex_branch_taken & (lu_hazard | md_hazard);

    assign bubble        = ex_branch_taken | stall_if_id;
    assign accept_muldiv = ~bubble & id_valid & id_ctrl[MULDIV];

    assign md_busy   = (state_q == ST_MD_WAIT);
    assign fsm_state = state_q;

    id_ex_ctrl_pipe_reg #(
        .CTRL_W (CTRL_W)
    ) u_id_ex (
        .clock    (clock),
        .reset_n  (reset_n),
        .bubble   (bubble),
        .id_valid (id_valid),
        .id_ctrl  (id_ctrl),
        .id_rt    (id_rt),
        .id_rd    (id_rd),
        .ex_valid (ex_valid),
        .ex_ctrl  (ex_ctrl),
        .ex_rt    (ex_rt),
        .ex_rd    (ex_rd)
    );

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a branch never cancels an older in-flight muldiv
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept_muldiv) begin
                    state_d = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (md_done && !accept_muldiv) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Saturating count of stall cycles (flush cycles are not stalls)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_count <= '0;
        end else if (stall_if_id && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl. Inputs change 1 ns after a
// rising edge; combinational outputs are sampled on the falling edge and
// registered outputs 1 ns after the rising edge.
module tb_pipeline_hazard_ctrl;

    localparam int CTRL_W = 8;
    localparam int CNT_W  = 16;

    // Control bundles used as stimulus
    localparam logic [7:0] C_LW   = 8'h1B; // regwrite|memread|memtoreg|alusrc
    localparam logic [7:0] C_ADDI = 8'h31; // regwrite|alusrc|addi
    localparam logic [7:0] C_ADD  = 8'h01; // regwrite
    localparam logic [7:0] C_SW   = 8'h04; // memwrite
    localparam logic [7:0] C_MULT = 8'h80; // muldiv
    localparam logic [7:0] C_MFHI = 8'h01; // regwrite, reads HI

    logic              clock;
    logic              reset_n;
    logic              id_valid;
    logic [CTRL_W-1:0] id_ctrl;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic [4:0]        id_rd;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_uses_hilo;
    logic              ex_branch_taken;
    logic              md_done;
    logic              ex_valid;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_rt;
    logic [4:0]        ex_rd;
    logic              stall_if_id;
    logic              flush_if_id;
    logic              md_busy;
    logic [CNT_W-1:0]  stall_count;
    logic [1:0]        fsm_state;

    int checks;
    int failures;

    pipeline_hazard_ctrl #(
        .CTRL_W (CTRL_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .id_valid        (id_valid),
        .id_ctrl         (id_ctrl),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_rd           (id_rd),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_uses_hilo    (id_uses_hilo),
        .ex_branch_taken (ex_branch_taken),
        .md_done         (md_done),
        .ex_valid        (ex_valid),
        .ex_ctrl         (ex_ctrl),
        .ex_rt           (ex_rt),
        .ex_rd           (ex_rd),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .md_busy         (md_busy),
        .stall_count     (stall_count),
        .fsm_state       (fsm_state)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic drive_id(input logic v, input logic [7:0] c, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd,
                            input logic urs, input logic urt, input logic uhl);
        id_valid     = v;
        id_ctrl      = c;
        id_rs        = rs;
        id_rt        = rt;
        id_rd        = rd;
        id_uses_rs   = urs;
        id_uses_rt   = urt;
        id_uses_hilo = uhl;
    endtask

    task automatic idle_id();
        drive_id(1'b0, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle_id();
        ex_branch_taken = 1'b0;
        md_done         = 1'b0;
        reset_n         = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive_id(1'b1, C_LW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        ex_branch_taken = 1'b1;
        md_done         = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_rt !== 5'd0 || ex_rd !== 5'd0) begin
            failures++;
            $display("FAIL reset_idex: got v=%b c=%h rt=%0d rd=%0d want 0 0 0 0", ex_valid, ex_ctrl, ex_rt, ex_rd);
        end
        checks++;
        if (flush_if_id !== 1'b0 || stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctl: got flush=%b stall=%b want 0 0", flush_if_id, stall_if_id);
        end
        checks++;
        if (md_busy !== 1'b0 || stall_count !== 16'h0000 || fsm_state !== 2'b00) begin
            failures++;
            $display("FAIL reset_fsm: got busy=%b cnt=%h st=%b want 0 0000 00", md_busy, stall_count, fsm_state);
        end
        ex_branch_taken = 1'b0;
        md_done         = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        // Invalid ID slot: control zeroed, register fields still pass through
        drive_id(1'b0, 8'hFF, 5'd3, 5'd12, 5'd13, 1'b1, 1'b1, 1'b1);
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_rt !== 5'd12 || ex_rd !== 5'd13) begin
            failures++;
            $display("FAIL invalid_id: got v=%b c=%h rt=%0d rd=%0d want 0 00 12 13", ex_valid, ex_ctrl, ex_rt, ex_rd);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_LW || ex_rt !== 5'd8) begin
            failures++;
            $display("FAIL lu_lw_in_ex: got v=%b c=%h rt=%0d want 1 1b 8", ex_valid, ex_ctrl, ex_rt);
        end
        drive_id(1'b1, C_ADDI, 5'd8, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b1 || flush_if_id !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall: got stall=%b flush=%b want 1 0", stall_if_id, flush_if_id);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_count !== 16'd1) begin
            failures++;
            $display("FAIL lu_bubble: got v=%b c=%h cnt=%0d want 0 00 1", ex_valid, ex_ctrl, stall_count);
        end
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL lu_release: got stall=%b want 0", stall_if_id);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_ADDI || ex_rt !== 5'd9 || ex_rd !== 5'd3 || stall_count !== 16'd1) begin
            failures++;
            $display("FAIL lu_addi_ex: got v=%b c=%h rt=%0d rd=%0d cnt=%0d want 1 31 9 3 1",
                     ex_valid, ex_ctrl, ex_rt, ex_rd, stall_count);
        end
    endtask

    task automatic test_zero_reg();
        do_reset();
        drive_id(1'b1, C_LW, 5'd2, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg_stall: got stall=%b want 0", stall_if_id);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_ADD || ex_rd !== 5'd7 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL zero_reg_load: got v=%b c=%h rd=%0d cnt=%0d want 1 01 7 0", ex_valid, ex_ctrl, ex_rd, stall_count);
        end
        // Matching register numbers but no operand-use flags: no hazard
        drive_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, 8'h00, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL no_use_flags: got stall=%b want 0", stall_if_id);
        end
        tick();
        // rt operand match on a store
        drive_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, C_SW, 5'd1, 5'd8, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b1) begin
            failures++;
            $display("FAIL lu_rt_match: got stall=%b want 1", stall_if_id);
        end
        tick();
        idle_id();
    endtask

    task automatic test_branch_flush();
        do_reset();
        drive_id(1'b1, C_LW, 5'd2, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        drive_id(1'b1, C_ADDI, 5'd8, 5'd9, 5'd3, 1'b1, 1'b0, 1'b0);
        ex_branch_taken = 1'b1;
        @(negedge clock);
        checks++;
        if (flush_if_id !== 1'b1 || stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL br_priority: got flush=%b stall=%b want 1 0", flush_if_id, stall_if_id);
        end
        tick();
        ex_branch_taken = 1'b0;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL br_bubble: got v=%b c=%h cnt=%0d want 0 00 0", ex_valid, ex_ctrl, stall_count);
        end
        idle_id();
    endtask

    task automatic test_muldiv();
        do_reset();
        drive_id(1'b1, C_MULT, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        checks++;
        if (md_busy !== 1'b1 || fsm_state !== 2'b01 || ex_ctrl !== C_MULT) begin
            failures++;
            $display("FAIL md_enter: got busy=%b st=%b c=%h want 1 01 80", md_busy, fsm_state, ex_ctrl);
        end
        drive_id(1'b1, C_MFHI, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            checks++;
            if (stall_if_id !== 1'b1) begin
                failures++;
                $display("FAIL md_stall_c%0d: got stall=%b want 1", i, stall_if_id);
            end
            tick();
            checks++;
            if (ex_valid !== 1'b0 || md_busy !== 1'b1) begin
                failures++;
                $display("FAIL md_wait_c%0d: got v=%b busy=%b want 0 1", i, ex_valid, md_busy);
            end
        end
        md_done = 1'b1;
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL md_done_stall: got stall=%b want 0", stall_if_id);
        end
        tick();
        md_done = 1'b0;
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_MFHI || ex_rd !== 5'd10 || md_busy !== 1'b0 || stall_count !== 16'd4) begin
            failures++;
            $display("FAIL md_mfhi_accept: got v=%b c=%h rd=%0d busy=%b cnt=%0d want 1 01 10 0 4",
                     ex_valid, ex_ctrl, ex_rd, md_busy, stall_count);
        end
        // Stray md_done while idle must not disturb the FSM
        idle_id();
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        checks++;
        if (md_busy !== 1'b0 || fsm_state !== 2'b00) begin
            failures++;
            $display("FAIL md_done_in_run: got busy=%b st=%b want 0 00", md_busy, fsm_state);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        drive_id(1'b1, C_MULT, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, C_MULT, 5'd6, 5'd7, 5'd0, 1'b1, 1'b1, 1'b0);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stall: got stall=%b want 1", stall_if_id);
        end
        tick();
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_MULT || ex_rt !== 5'd7 || md_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_stay_wait: got v=%b c=%h rt=%0d busy=%b want 1 80 7 1", ex_valid, ex_ctrl, ex_rt, md_busy);
        end
        // Taken branch while the second muldiv is in flight
        drive_id(1'b1, C_MFHI, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        ex_branch_taken = 1'b1;
        @(negedge clock);
        checks++;
        if (flush_if_id !== 1'b1 || stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL b2b_branch: got flush=%b stall=%b want 1 0", flush_if_id, stall_if_id);
        end
        tick();
        ex_branch_taken = 1'b0;
        checks++;
        if (md_busy !== 1'b1 || ex_valid !== 1'b0 || stall_count !== 16'd1) begin
            failures++;
            $display("FAIL b2b_no_abort: got busy=%b v=%b cnt=%0d want 1 0 1", md_busy, ex_valid, stall_count);
        end
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        checks++;
        if (md_busy !== 1'b0 || ex_valid !== 1'b1 || ex_ctrl !== C_MFHI) begin
            failures++;
            $display("FAIL b2b_finish: got busy=%b v=%b c=%h want 0 1 01", md_busy, ex_valid, ex_ctrl);
        end
        idle_id();
    endtask

    task automatic test_saturation();
        do_reset();
        drive_id(1'b1, C_MULT, 5'd4, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, C_MFHI, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        repeat (65534) @(posedge clock);
        #1;
        checks++;
        if (stall_count !== 16'hFFFE || md_busy !== 1'b1) begin
            failures++;
            $display("FAIL sat_preload: got cnt=%h busy=%b want fffe 1", stall_count, md_busy);
        end
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (stall_count !== 16'hFFFF || stall_if_id !== 1'b1) begin
            failures++;
            $display("FAIL sat_hold: got cnt=%h stall=%b want ffff 1", stall_count, stall_if_id);
        end
        md_done = 1'b1;
        tick();
        md_done = 1'b0;
        idle_id();
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive_id(1'b1, C_MULT, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b0);
        tick();
        drive_id(1'b1, C_MFHI, 5'd0, 5'd0, 5'd10, 1'b0, 1'b0, 1'b1);
        @(negedge clock);
        checks++;
        if (stall_if_id !== 1'b1 || md_busy !== 1'b1 || ex_valid !== 1'b1) begin
            failures++;
            $display("FAIL rm_setup: got stall=%b busy=%b v=%b want 1 1 1", stall_if_id, md_busy, ex_valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (ex_valid !== 1'b0 || ex_ctrl !== 8'h00 || ex_rt !== 5'd0 || ex_rd !== 5'd0) begin
            failures++;
            $display("FAIL rm_async_idex: got v=%b c=%h rt=%0d rd=%0d want 0 00 0 0", ex_valid, ex_ctrl, ex_rt, ex_rd);
        end
        checks++;
        if (md_busy !== 1'b0 || stall_if_id !== 1'b0 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL rm_async_ctl: got busy=%b stall=%b cnt=%0d want 0 0 0", md_busy, stall_if_id, stall_count);
        end
        #1;
        reset_n = 1'b1;
        #1;
        checks++;
        if (stall_if_id !== 1'b0) begin
            failures++;
            $display("FAIL rm_release_stall: got stall=%b want 0", stall_if_id);
        end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_ctrl !== C_MFHI || md_busy !== 1'b0 || stall_count !== 16'd0) begin
            failures++;
            $display("FAIL rm_first_edge: got v=%b c=%h busy=%b cnt=%0d want 1 01 0 0", ex_valid, ex_ctrl, md_busy, stall_count);
        end
        idle_id();
    endtask

    // Test sequence and report
    initial begin
        checks          = 0;
        failures        = 0;
        reset_n         = 1'b0;
        ex_branch_taken = 1'b0;
        md_done         = 1'b0;
        idle_id();
        test_reset();
        test_load_use();
        test_zero_reg();
        test_branch_flush();
        test_muldiv();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
